// File: rtl/rpn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpn_pkg
// Description : Shared constants for the RPN sequencer: opcodes, error codes
//               and the controller state encoding.
//               Optional feature macro: RPN_DIV_EN (enables OP_DIV / OP_MOD).
// Revision    : 1.0 - initial release
// ============================================================================
package rpn_pkg;

    // Opcodes carried on tok_op (a = second, b = first)
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_DUP  = 4'd6;
    localparam logic [3:0] OP_DROP = 4'd7;
    localparam logic [3:0] OP_DIV  = 4'd8;
    localparam logic [3:0] OP_MOD  = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd15;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNDER   = 2'd1;
    localparam logic [1:0] ERR_OVER    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    // Controller states
    localparam int         ST_W     = 2;
    localparam logic [1:0] ST_FLUSH = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_DIVW  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rpn_divu.sv
`default_nettype none
// ============================================================================
// Module      : rpn_divu
// Description : 16-bit unsigned restoring divider, one quotient bit per cycle.
//               The first bit is resolved on the start edge, so done pulses
//               16 cycles after the start cycle. Only built with RPN_DIV_EN.
// Ports       : clk, rst (sync, active-high), start, a (dividend),
//               b (divisor) -> busy, done (1-cycle pulse), quo, rem
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef RPN_DIV_EN
module rpn_divu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] quo,
    output logic [15:0] rem
);

    logic        r_busy;
    logic        r_done;
    logic [15:0] r_quo;
    logic [15:0] r_rem;
    logic [15:0] r_b;
    logic [3:0]  r_cnt;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. The partial remainder
    // is always below the divisor, so the difference fits in 16 bits.
    function automatic logic [31:0] f_step(input logic [15:0] rem_in,
                                           input logic [15:0] quo_in,
                                           input logic [15:0] dvs);
        logic [16:0] l_trial;
        logic [15:0] l_diff;
        l_trial = {rem_in, quo_in[15]};
        l_diff  = l_trial[15:0] - dvs;
        if (l_trial >= {1'b0, dvs})
            f_step = {l_diff, quo_in[14:0], 1'b1};
        else
            f_step = {l_trial[15:0], quo_in[14:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_quo  <= 16'd0;
            r_rem  <= 16'd0;
            r_b    <= 16'd0;
            r_cnt  <= 4'd0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                {r_rem, r_quo} <= f_step(16'd0, a, b);
                r_b            <= b;
                r_cnt          <= 4'd0;
                r_busy         <= 1'b1;
            end else if (r_busy) begin
                {r_rem, r_quo} <= f_step(r_rem, r_quo, r_b);
                r_cnt          <= r_cnt + 4'd1;
                // 15 further steps after the start edge complete all 16 bits
                if (r_cnt == 4'd14) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign quo  = r_quo;
    assign rem  = r_rem;

endmodule
`endif
`default_nettype wire

// File: rtl/rpn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rpn_ctrl
// Description : RPN token sequencer. Turns number/operator tokens into stack
//               write/pop commands, tracks the stack depth itself and flags
//               underflow, overflow and illegal operations.
//               Optional feature macro: RPN_DIV_EN (DIV/MOD via rpn_divu).
// Ports       : clk, rst (sync, active-high)
//               tok_valid/tok_ready/tok_is_num/tok_val/tok_op - token input
//               stk_wen/stk_din/stk_pop - stack commands
//               stk_first/stk_second    - top two stack entries
//               res_valid/res_data      - EQ result pulse
//               err_valid/err_code      - rejected-token pulse
// Revision    : 1.0 - initial release
// ============================================================================
module rpn_ctrl
    import rpn_pkg::*;
#(
    parameter int STACK_ADDR_WIDTH = 5,
    parameter int DEPTH_MAX        = 2**STACK_ADDR_WIDTH - 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tok_valid,
    output logic        tok_ready,
    input  logic        tok_is_num,
    input  logic [15:0] tok_val,
    input  logic [3:0]  tok_op,
    output logic        stk_wen,
    output logic [15:0] stk_din,
    output logic [1:0]  stk_pop,
    input  logic [15:0] stk_first,
    input  logic [15:0] stk_second,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        err_valid,
    output logic [1:0]  err_code
);

    localparam int                          c_DW         = STACK_ADDR_WIDTH + 1;
    localparam logic [c_DW-1:0]             c_DEPTH_MAX  = c_DW'(DEPTH_MAX);
    localparam logic [c_DW-1:0]             c_ONE        = c_DW'(1);
    localparam logic [c_DW-1:0]             c_TWO        = c_DW'(2);
    localparam logic [STACK_ADDR_WIDTH-1:0] c_FLUSH_LAST = '1;

    logic [ST_W-1:0]             r_state;
    logic [STACK_ADDR_WIDTH-1:0] r_flush_cnt;
    logic [c_DW-1:0]             r_depth;
    logic                        r_is_num;
    logic [15:0]                 r_val;
    logic [3:0]                  r_op;
    logic [15:0]                 r_res_data;
    logic [1:0]                  r_err_code;

    logic [1:0]  w_code;
    logic [15:0] w_alu;
    logic [15:0] w_prod;
    logic        w_depth_inc;
    logic        w_depth_dec;

`ifdef RPN_DIV_EN
    logic        r_div_run;
    logic        r_div_err;
    logic        w_div_start;
    logic        w_div_busy;
    logic        w_div_done;
    logic [15:0] w_quo;
    logic [15:0] w_rem;
    logic [1:0]  w_div_code;

    rpn_divu u_divu (
        .clk   (clk),
        .rst   (rst),
        .start (w_div_start),
        .a     (stk_second),
        .b     (stk_first),
        .busy  (w_div_busy),
        .done  (w_div_done),
        .quo   (w_quo),
        .rem   (w_rem)
    );

    // Checked on DIVW entry; underflow wins because first/second are
    // meaningless without two entries.
    assign w_div_code = (r_depth < c_TWO)      ? ERR_UNDER   :
                        (stk_first == 16'd0)   ? ERR_ILLEGAL : ERR_NONE;
`endif

    assign w_prod = stk_second * stk_first;

    // Legality of the latched token against the tracked depth
    always_comb begin
        w_code = ERR_NONE;
        if (r_is_num) begin
            if (r_depth >= c_DEPTH_MAX) w_code = ERR_OVER;
        end else begin
            case (r_op)
                OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: begin
                    if (r_depth < c_TWO) w_code = ERR_UNDER;
                end
                OP_DUP: begin
                    if (r_depth < c_ONE)             w_code = ERR_UNDER;
                    else if (r_depth >= c_DEPTH_MAX) w_code = ERR_OVER;
                end
                OP_DROP, OP_EQ: begin
                    if (r_depth < c_ONE) w_code = ERR_UNDER;
                end
                // DIV/MOD never reach EXEC when the divider exists
                default: w_code = ERR_ILLEGAL;
            endcase
        end
    end

    always_comb begin
        case (r_op)
            OP_ADD:  w_alu = stk_second + stk_first;
            OP_SUB:  w_alu = stk_second - stk_first;
            OP_MUL:  w_alu = w_prod;
            OP_AND:  w_alu = stk_second & stk_first;
            OP_OR:   w_alu = stk_second | stk_first;
            OP_XOR:  w_alu = stk_second ^ stk_first;
            default: w_alu = stk_first;
        endcase
    end

    // Stack commands and pulses decode from registered state; the stack
    // applies them at the edge closing the cycle.
    always_comb begin
        tok_ready   = 1'b0;
        stk_wen     = 1'b0;
        stk_din     = 16'd0;
        stk_pop     = 2'd0;
        res_valid   = 1'b0;
        res_data    = r_res_data;
        err_valid   = 1'b0;
        err_code    = r_err_code;
        w_depth_inc = 1'b0;
        w_depth_dec = 1'b0;
`ifdef RPN_DIV_EN
        w_div_start = 1'b0;
`endif
        if (!rst) begin
            case (r_state)
                ST_FLUSH: stk_pop = 2'd1;
                ST_IDLE:  tok_ready = 1'b1;
                ST_EXEC: begin
                    if (w_code != ERR_NONE) begin
                        err_valid = 1'b1;
                        err_code  = w_code;
                    end else if (r_is_num) begin
                        stk_wen     = 1'b1;
                        stk_din     = r_val;
                        w_depth_inc = 1'b1;
                    end else begin
                        case (r_op)
                            OP_DUP: begin
                                stk_wen     = 1'b1;
                                stk_din     = stk_first;
                                w_depth_inc = 1'b1;
                            end
                            OP_DROP: begin
                                stk_pop     = 2'd1;
                                w_depth_dec = 1'b1;
                            end
                            OP_EQ: begin
                                res_valid = 1'b1;
                                res_data  = stk_first;
                            end
                            default: begin
                                stk_wen     = 1'b1;
                                stk_pop     = 2'd2;
                                stk_din     = w_alu;
                                w_depth_dec = 1'b1;
                            end
                        endcase
                    end
                end
`ifdef RPN_DIV_EN
                ST_DIVW: begin
                    if (r_div_err) begin
                        // code was captured into r_err_code on entry
                        err_valid = 1'b1;
                    end else if (r_div_run) begin
                        if (w_div_done) begin
                            stk_wen     = 1'b1;
                            stk_pop     = 2'd2;
                            stk_din     = (r_op == OP_MOD) ? w_rem : w_quo;
                            w_depth_dec = 1'b1;
                        end
                    end else if (w_div_code == ERR_NONE && !w_div_busy) begin
                        w_div_start = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= '0;
            r_depth     <= '0;
            r_is_num    <= 1'b0;
            r_val       <= 16'd0;
            r_op        <= 4'd0;
            r_res_data  <= 16'd0;
            r_err_code  <= ERR_NONE;
`ifdef RPN_DIV_EN
            r_div_run   <= 1'b0;
            r_div_err   <= 1'b0;
`endif
        end else begin
            if (w_depth_inc)      r_depth <= r_depth + 1'b1;
            else if (w_depth_dec) r_depth <= r_depth - 1'b1;

            case (r_state)
                ST_FLUSH: begin
                    // The stack pointer has no reset: pop once per entry
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                    if (r_flush_cnt == c_FLUSH_LAST) begin
                        r_depth <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (tok_valid) begin
                        r_is_num <= tok_is_num;
                        r_val    <= tok_val;
                        r_op     <= tok_op;
`ifdef RPN_DIV_EN
                        if (!tok_is_num && (tok_op == OP_DIV || tok_op == OP_MOD))
                            r_state <= ST_DIVW;
                        else
`endif
                            r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_code != ERR_NONE) r_err_code <= w_code;
                    if (res_valid)          r_res_data <= stk_first;
                    r_state <= ST_IDLE;
                end
`ifdef RPN_DIV_EN
                ST_DIVW: begin
                    if (r_div_err) begin
                        r_div_err <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (r_div_run) begin
                        if (w_div_done) begin
                            r_div_run <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end else if (w_div_code != ERR_NONE) begin
                        r_div_err  <= 1'b1;
                        r_err_code <= w_div_code;
                    end else if (!w_div_busy) begin
                        r_div_run <= 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rpn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rpn_ctrl
// Description : Self-checking bench for rpn_ctrl. Contains a behavioural
//               stack (pointer without reset) and a queue-based RPN reference
//               model; expected results/errors go into a scoreboard queue that
//               a monitor drains whenever res_valid or err_valid pulses.
//               Honours RPN_DIV_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rpn_ctrl;

    typedef struct packed {
        logic        is_err;
        logic [15:0] val;
    } exp_t;

`ifdef RPN_DIV_EN
    localparam bit c_DIV_EN = 1'b1;
`else
    localparam bit c_DIV_EN = 1'b0;
`endif
    localparam int c_DEPTH_MAX = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic        tok_is_num = 1'b0;
    logic [15:0] tok_val = 16'd0;
    logic [3:0]  tok_op = 4'd0;
    logic        stk_wen;
    logic [15:0] stk_din;
    logic [1:0]  stk_pop;
    logic [15:0] stk_first;
    logic [15:0] stk_second;
    logic        res_valid;
    logic [15:0] res_data;
    logic        err_valid;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rpn_ctrl #(.STACK_ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_is_num (tok_is_num),
        .tok_val    (tok_val),
        .tok_op     (tok_op),
        .stk_wen    (stk_wen),
        .stk_din    (stk_din),
        .stk_pop    (stk_pop),
        .stk_first  (stk_first),
        .stk_second (stk_second),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .err_valid  (err_valid),
        .err_code   (err_code)
    );

    // ---------------- behavioural stack (pointer starts at garbage) --------
    logic [15:0] mem [32];
    int          sp = 13;
    int          sp_after_pop;

    initial for (int i = 0; i < 32; i++) mem[i] = 16'hA500 + 16'(i);

    assign sp_after_pop = (sp > int'(stk_pop)) ? sp - int'(stk_pop) : 0;
    assign stk_first    = (sp >= 1) ? mem[(sp - 1) % 32] : 16'h0;
    assign stk_second   = (sp >= 2) ? mem[(sp - 2) % 32] : 16'h0;

    always @(posedge clk) begin
        if (stk_wen) begin
            mem[sp_after_pop % 32] <= stk_din;
            sp                     <= sp_after_pop + 1;
        end else begin
            sp <= sp_after_pop;
        end
    end

    // ---------------- reference model + scoreboard -------------------------
    logic [15:0] ref_stk[$];
    exp_t        exp_q[$];

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    endtask

    function automatic void exp_err(input logic [1:0] code);
        exp_q.push_back('{is_err: 1'b1, val: {14'd0, code}});
    endfunction

    function automatic void model(input bit is_num, input logic [15:0] v, input logic [3:0] op);
        int d;
        logic [15:0] a, b;
        d = ref_stk.size();
        b = (d >= 1) ? ref_stk[d-1] : 16'h0;
        a = (d >= 2) ? ref_stk[d-2] : 16'h0;
        if (is_num) begin
            if (d >= c_DEPTH_MAX) exp_err(2'd2);
            else ref_stk.push_back(v);
            return;
        end
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                if (d < 2) exp_err(2'd1);
                else begin
                    void'(ref_stk.pop_back());
                    void'(ref_stk.pop_back());
                    case (op)
                        4'd0:    ref_stk.push_back(16'((32'(a) + 32'(b)) % 65536));
                        4'd1:    ref_stk.push_back(16'((32'(a) + 65536 - 32'(b)) % 65536));
                        4'd2:    ref_stk.push_back(16'((32'(a) * 32'(b)) % 65536));
                        4'd3:    ref_stk.push_back(a & b);
                        4'd4:    ref_stk.push_back(a | b);
                        default: ref_stk.push_back(a ^ b);
                    endcase
                end
            end
            4'd8, 4'd9: begin
                if (!c_DIV_EN)   exp_err(2'd3);
                else if (d < 2)  exp_err(2'd1);
                else if (b == 0) exp_err(2'd3);
                else begin
                    void'(ref_stk.pop_back());
                    void'(ref_stk.pop_back());
                    ref_stk.push_back((op == 4'd8) ? a / b : a % b);
                end
            end
            4'd6: begin
                if (d < 1)                 exp_err(2'd1);
                else if (d >= c_DEPTH_MAX) exp_err(2'd2);
                else ref_stk.push_back(b);
            end
            4'd7: begin
                if (d < 1) exp_err(2'd1);
                else void'(ref_stk.pop_back());
            end
            4'd15: begin
                if (d < 1) exp_err(2'd1);
                else exp_q.push_back('{is_err: 1'b0, val: b});
            end
            default: exp_err(2'd3);
        endcase
    endfunction

    // ---------------- monitor ----------------------------------------------
    always @(negedge clk) begin
        if (!rst && (res_valid || err_valid)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1'b0, {15'd0, res_valid, 14'd0, err_valid, 1'b0}, 32'd0);
            end else begin
                if (err_valid) begin
                    check("err_expected", exp_q[0].is_err == 1'b1, 32'(err_code), 32'(exp_q[0].val));
                    check("err_code", err_code == exp_q[0].val[1:0], 32'(err_code), 32'(exp_q[0].val));
                    check("err_no_stack_cmd", !stk_wen && stk_pop == 2'd0, {29'd0, stk_wen, stk_pop}, 32'd0);
                end else begin
                    check("res_expected", exp_q[0].is_err == 1'b0, 32'(res_data), 32'(exp_q[0].val));
                    check("res_data", res_data == exp_q[0].val, 32'(res_data), 32'(exp_q[0].val));
                end
                exp_q.delete(0);
            end
        end
    end

    // ---------------- driver tasks -----------------------------------------
    task automatic send(input bit is_num, input logic [15:0] v, input logic [3:0] op);
        int n;
        @(negedge clk);
        tok_is_num = is_num;
        tok_val    = v;
        tok_op     = op;
        tok_valid  = 1'b1;
        n = 0;
        while (!tok_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tok_ready) begin
            check("tok_ready_timeout", 1'b0, 32'(n), 32'd100);
            tok_valid = 1'b0;
            return;
        end
        model(is_num, v, op);
        @(posedge clk);
        #1 tok_valid = 1'b0;
    endtask

    task automatic push(input logic [15:0] v);
        send(1'b1, v, 4'd0);
    endtask

    task automatic op(input logic [3:0] o);
        send(1'b0, 16'd0, o);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        int n;
        int bad;
        wait_drain();
        @(negedge clk);
        rst       = 1'b1;
        tok_valid = 1'b0;
        #1;
        check("rst_outputs_zero", {tok_ready, stk_wen, stk_pop, res_valid, err_valid} == 6'd0,
              {26'd0, tok_ready, stk_wen, stk_pop, res_valid, err_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ref_stk.delete();
        exp_q.delete();
        #1;
        check("res_data_after_rst", res_data == 16'd0, 32'(res_data), 32'd0);
        check("err_code_after_rst", err_code == 2'd0, 32'(err_code), 32'd0);
        n = 0;
        bad = 0;
        while (!tok_ready && n < 200) begin
            if (stk_pop != 2'd1 || stk_wen) bad++;
            @(negedge clk);
            #1;
            n++;
        end
        check("flush_len", n == 32, 32'(n), 32'd32);
        check("flush_pop_only", bad == 0, 32'(bad), 32'd0);
    endtask

    // ---------------- main sequence ----------------------------------------
    initial begin
        repeat (3) @(negedge clk);
        do_reset();

        // underflow right after flush; no write may occur
        op(4'd0);
        // 3 4 ADD EQ -> 7
        push(16'd3); push(16'd4); op(4'd0); op(4'd15); op(4'd7);
        // 5 9 SUB EQ -> 0xFFFC
        push(16'd5); push(16'd9); op(4'd1); op(4'd15); op(4'd7);
        // illegal opcode and MUL wrap
        op(4'd12);
        push(16'h1234); push(16'h0100); op(4'd2); op(4'd15); op(4'd7);

        // overflow boundary: 31 pushes fit, the 32nd does not
        do_reset();
        for (int i = 0; i < 32; i++) push(16'(i + 1));
        op(4'd15);
        op(4'd7);
        push(16'hBEEF);
        op(4'd15);
        op(4'd6);

        // DIV / MOD (illegal without the divider)
        do_reset();
        push(16'd100); push(16'd7); op(4'd8); op(4'd15); op(4'd7);
        push(16'd100); push(16'd7); op(4'd9); op(4'd15); op(4'd7);
        push(16'd5); push(16'd0); op(4'd8); op(4'd15);
        op(4'd9);

`ifdef RPN_DIV_EN
        // reset while the divider is running: no write, no result
        do_reset();
        push(16'd100); push(16'd7); op(4'd8);
        repeat (4) @(negedge clk);
        do_reset();
        push(16'd42); op(4'd15);
`endif

        // randomized token stream
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [15:0] v;
            r = $urandom_range(0, 99);
            v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            if (r < 45)      push(v);
            else if (r < 58) op(4'd15);
            else             op(4'($urandom_range(0, 15)));
        end

        repeat (25) @(negedge clk);
        wait_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // hard upper bound on simulated time
    initial begin
        #500000;
        $display("FAIL global_timeout: got %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
